relay_arm_framer: RTL
=====================

Name: relay_arm_framer

Overview:
- Downstream of the relay stage. Consumes the decoded relay bit stream: one bit per 0.8475 MHz strobe.
- Packs bits into bytes, gated by start-of-communication detection, and buffers them in a small byte FIFO.
- Serializes bytes to the ARM over SSP, generating its own ssp_clk/ssp_frame.
- Replaces the ad-hoc 80-bit debug capture path to the ARM.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 4
SSP_DIV, 8, clk cycles per ssp_clk period; even, >= 4
IDLE_BYTES, 2, consecutive all-zero bytes that terminate a capture

Ports:
clk  input  1  13.56 MHz system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  capture enable; low forces packer to IDLE
bit_in  input  1  decoded relay bit, valid when bit_valid=1
bit_valid  input  1  single-cycle strobe per decoded bit
ssp_clk  output  1  SSP clock to ARM
ssp_frame  output  1  high for the first bit period of each byte
ssp_din  output  1  serial data to ARM, MSB first
overflow  output  1  sticky: a byte was dropped on a full FIFO
fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, while reset=0): ssp_clk=0, ssp_frame=0, ssp_din=0, overflow=0, fifo_level=0. FIFO empty, all counters 0, packer IDLE, serializer S_IDLE. Takes effect immediately, including mid-byte.

Packer FSM (IDLE, PACK):
- IDLE:
  - bit_valid with bit_in=0 is ignored.
  - bit_valid with bit_in=1 enters PACK; that bit becomes bit7 of the byte.
- PACK:
  - Each bit_valid shifts bit_in in, MSB first.
  - On the 8th bit, the byte is pushed on the next clk edge.
  - The zero-byte counter increments on each 0x00 push and clears on any nonzero push.
  - After the IDLE_BYTES-th consecutive 0x00 push, return to IDLE. The terminating zero bytes are transmitted.
- enable=0: packer goes to IDLE on the next edge; a partial byte is discarded. FIFO and serializer are unaffected.

FIFO:
- Push when full: byte dropped, overflow set. overflow clears only on reset.
- Simultaneous push and pop when full: both succeed; level unchanged; overflow not set.
- fifo_level reflects the post-edge count.

SSP clock:
- A free-running divider counts 0..SSP_DIV-1.
- ssp_clk=1 for counts 0..SSP_DIV/2-1, 0 otherwise.
- The "rising point" is the clk edge where the count wraps to 0.

Serializer FSM (S_IDLE, S_SHIFT):
- S_IDLE, at a rising point with FIFO non-empty:
  - pop and load the shift register;
  - drive ssp_din=bit7 and ssp_frame=1;
  - enter S_SHIFT.
- S_SHIFT:
  - Each subsequent rising point outputs the next bit; ssp_frame=0.
  - At the rising point after bit0: if FIFO non-empty, load the next byte back-to-back with ssp_frame=1; else ssp_din=0 and return to S_IDLE.
- ssp_din/ssp_frame change only at rising points; the ARM samples on the ssp_clk falling edge.
- Latency, push to ssp_frame=1 from S_IDLE: 1 to SSP_DIV clk cycles.

Optional Feature:
- Macro: RELAY_ARM_FRAMER_TIMESTAMP_EN
- With it defined:
  - A 16-bit free-running counter increments on every bit_valid and wraps at 0xFFFF.
  - On each IDLE->PACK transition, two header bytes are pushed before the first data byte: counter[15:8], then counter[7:0], sampled on the triggering strobe.
  - If fewer than 2 free entries exist, both header bytes are dropped and overflow is set. Data packing proceeds regardless.
  - The header does not count toward IDLE_BYTES.
- Without it: no counter and no header; only data bytes are pushed.

Test Plan:
- Defaults; bits 1,0,1,1,0,0,1,0 then 16 zeros, one strobe per 16 clk -> SSP emits 0xB2, 0x00, 0x00 MSB first, ssp_frame=1 on bit7 of each; packer returns to IDLE; a further 40 zeros produce no output.
- 5 zero bits, then 1,1,0,0,0,0,0,0 + 16 zeros -> leading zeros ignored; emitted bytes 0xC0, 0x00, 0x00; fifo_level returns to 0.
- bit_valid every clk, bit_in=1 for 160 bits -> overflow=1 by the 11th byte push; every emitted byte is 0xFF; fifo_level never exceeds 8.
- enable=1, bits 1,1,0 then enable=0 -> nothing pushed; fifo_level=0; ssp_frame stays 0.
- Reset pulled low during bit 3 of an SSP byte -> ssp_clk/ssp_frame/ssp_din=0 within the same cycle; after release, fifo_level=0, overflow=0, and no stale bits emitted.
- TIMESTAMP_EN, 0x1233 strobes already counted (zeros), then a 0xFF byte -> SSP emits 0x12, 0x33, 0xFF, …

Source files
------------

// File: rtl/relay_arm_framer.sv
// Packs decoded relay bits into bytes, buffers them in a small FIFO and streams them to the ARM over SSP.
// Define RELAY_ARM_FRAMER_TIMESTAMP_EN to prefix each capture with a 16-bit strobe-count header.
module relay_arm_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SSP_DIV    = 8,
  parameter int IDLE_BYTES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(SSP_DIV);
  localparam int ZW = $clog2(IDLE_BYTES + 1);

  typedef enum logic {P_IDLE, P_PACK} pk_state_t;
  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  pk_state_t     pk_state, pk_state_nx;
  logic [7:0]    pk_sr, pk_sr_nx;
  logic [2:0]    pk_cnt, pk_cnt_nx;
  logic [ZW-1:0] zero_cnt, zero_cnt_nx;
  logic          pend_vld, pend_vld_nx;
  logic [7:0]    pend_byte, pend_byte_nx;

  logic          push, pop, push_ok, full, empty, hdr_drop;
  logic [7:0]    push_data, rd_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  // A completed byte is parked in pend_byte and pushed on the following edge.
  always_comb begin
    pk_state_nx  = pk_state;
    pk_sr_nx     = pk_sr;
    pk_cnt_nx    = pk_cnt;
    zero_cnt_nx  = zero_cnt;
    pend_vld_nx  = 1'b0;
    pend_byte_nx = pend_byte;
    if (!enable) begin
      pk_state_nx = P_IDLE;
      pk_cnt_nx   = 3'd0;
      zero_cnt_nx = '0;
    end else if (bit_valid) begin
      case (pk_state)
        P_IDLE: begin
          if (bit_in) begin
            pk_state_nx = P_PACK;
            pk_sr_nx    = 8'h01;
            pk_cnt_nx   = 3'd1;
          end
        end
        default: begin
          pk_sr_nx = {pk_sr[6:0], bit_in};
          if (pk_cnt == 3'd7) begin
            pend_vld_nx  = 1'b1;
            pend_byte_nx = {pk_sr[6:0], bit_in};
            pk_cnt_nx    = 3'd0;
            if (pend_byte_nx == 8'h00) begin
              if (zero_cnt == ZW'(IDLE_BYTES - 1)) begin
                pk_state_nx = P_IDLE;
                zero_cnt_nx = '0;
              end else begin
                zero_cnt_nx = zero_cnt + 1'b1;
              end
            end else begin
              zero_cnt_nx = '0;
            end
          end else begin
            pk_cnt_nx = pk_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pk_state  <= P_IDLE;
      pk_sr     <= 8'h00;
      pk_cnt    <= 3'd0;
      zero_cnt  <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= 8'h00;
    end else begin
      pk_state  <= pk_state_nx;
      pk_sr     <= pk_sr_nx;
      pk_cnt    <= pk_cnt_nx;
      zero_cnt  <= zero_cnt_nx;
      pend_vld  <= pend_vld_nx;
      pend_byte <= pend_byte_nx;
    end
  end

`ifdef RELAY_ARM_FRAMER_TIMESTAMP_EN
  localparam logic [LW:0] ROOM_MAX = (LW + 1)'(FIFO_DEPTH - 2);
  logic        trigger, hdr_room;
  logic [15:0] ts_cnt, hdr_val;
  logic [1:0]  hdr_cnt;

  assign trigger  = enable && bit_valid && bit_in && (pk_state == P_IDLE);
  // Room is judged including a data byte still waiting to be pushed.
  assign hdr_room = ({1'b0, level} + {{LW{1'b0}}, pend_vld}) <= ROOM_MAX;
  assign hdr_drop = trigger && !hdr_room;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt  <= 16'h0000;
      hdr_val <= 16'h0000;
      hdr_cnt <= 2'd0;
    end else begin
      if (bit_valid) ts_cnt <= ts_cnt + 16'd1;
      if (trigger && hdr_room) begin
        hdr_cnt <= 2'd2;
        hdr_val <= ts_cnt;
      end else if (hdr_cnt != 2'd0) begin
        hdr_cnt <= hdr_cnt - 2'd1;
      end
    end
  end

  assign push      = pend_vld || (hdr_cnt != 2'd0);
  assign push_data = (hdr_cnt == 2'd2) ? hdr_val[15:8] :
                     (hdr_cnt == 2'd1) ? hdr_val[7:0]  : pend_byte;
`else
  assign push      = pend_vld;
  assign push_data = pend_byte;
  assign hdr_drop  = 1'b0;
`endif

  // push is valid, !full || pop is ready; a byte moves only when both hold, else it is dropped.
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && (!full || pop);
  assign rd_data = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (!push_ok && pop) level <= level - 1'b1;
      if ((push && !push_ok) || hdr_drop) overflow <= 1'b1;
    end
  end

  ser_state_t    s_state, s_state_nx;
  logic [7:0]    s_sr, s_sr_nx;
  logic [2:0]    s_cnt, s_cnt_nx;
  logic          din_nx, frame_nx, rise;
  logic [DW-1:0] div_cnt, div_nx;

  assign rise   = (div_cnt == DW'(SSP_DIV - 1));
  assign div_nx = rise ? '0 : div_cnt + 1'b1;

  // Serial outputs only move at rising points so they are stable at the ARM's falling-edge sample.
  always_comb begin
    s_state_nx = s_state;
    s_sr_nx    = s_sr;
    s_cnt_nx   = s_cnt;
    din_nx     = ssp_din;
    frame_nx   = ssp_frame;
    pop        = 1'b0;
    if (rise) begin
      if (s_state == S_SHIFT && s_cnt != 3'd0) begin
        s_sr_nx  = {s_sr[6:0], 1'b0};
        din_nx   = s_sr[6];
        frame_nx = 1'b0;
        s_cnt_nx = s_cnt - 3'd1;
      end else if (!empty) begin
        pop        = 1'b1;
        s_sr_nx    = rd_data;
        din_nx     = rd_data[7];
        frame_nx   = 1'b1;
        s_cnt_nx   = 3'd7;
        s_state_nx = S_SHIFT;
      end else begin
        din_nx     = 1'b0;
        frame_nx   = 1'b0;
        s_state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      ssp_clk   <= 1'b0;
      s_state   <= S_IDLE;
      s_sr      <= 8'h00;
      s_cnt     <= 3'd0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      div_cnt   <= div_nx;
      ssp_clk   <= (div_nx < DW'(SSP_DIV / 2));
      s_state   <= s_state_nx;
      s_sr      <= s_sr_nx;
      s_cnt     <= s_cnt_nx;
      ssp_din   <= din_nx;
      ssp_frame <= frame_nx;
    end
  end
endmodule
